// File: rtl/mhp_tx_scheduler.sv
// mhp_tx_scheduler: round-robin share of one MHP frame assembler among NUM_REQ sources
//   clk, rst         clock (rising edge), async active-high reset
//   i_req_valid      per-requester frame available
//   o_req_ready      per-requester accept strobe, combinational, IDLE only
//   i_req_frame      requester n frame at [n*FRAME_W +: FRAME_W]
//   o_frame          captured frame, held until next capture
//   o_frame_valid    frame offered to assembler until i_frame_ready
//   i_frame_ready    assembler takes o_frame
//   i_tx_done        assembler finished serialising the frame
//   o_grant          one-hot owner of the frame in flight, 0 otherwise
//   o_busy           scheduler not idle
//   o_timeout        one-cycle pulse when the done strobe never arrived
//   o_frame_count    frames completed with i_tx_done, wraps at 16 bits
module mhp_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int FRAME_W    = 408,
  parameter int IFG_CYCLES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*FRAME_W-1:0] i_req_frame,
  output logic [FRAME_W-1:0]         o_frame,
  output logic                       o_frame_valid,
  input  logic                       i_frame_ready,
  input  logic                       i_tx_done,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic                       o_busy,
  output logic                       o_timeout,
  output logic [15:0]                o_frame_count
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam int GW = IFG_CYCLES > 1 ? $clog2(IFG_CYCLES) : 1;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] OFFER     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] GAP       = 2'd3;
  localparam logic [1:0] AFTER     = IFG_CYCLES == 0 ? IDLE : GAP;
  logic [1:0]         state;
  logic [PW-1:0]      ptr, win;
  logic               found, wd_expired;
  logic [NUM_REQ-1:0] win_oh;
  logic [WW-1:0]      wd;
  logic [GW-1:0]      gap;
  logic [15:0]        frame_cnt;
  // scan downward so the requester closest to ptr is the last (winning) assignment
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
  assign win_oh        = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
  assign o_req_ready   = (state == IDLE && found && !rst) ? win_oh : '0;
  assign o_frame_valid = state == OFFER;
  assign o_busy        = state != IDLE;
  assign o_frame_count = frame_cnt;
  assign wd_expired    = wd == WW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      o_frame   <= '0;
      o_grant   <= '0;
      o_timeout <= 1'b0;
      wd        <= '0;
      gap       <= '0;
      frame_cnt <= '0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        IDLE: if (found) begin
          o_frame <= i_req_frame[int'(win)*FRAME_W +: FRAME_W];
          o_grant <= win_oh;
          ptr     <= PW'((int'(win) + 1) % NUM_REQ);
          state   <= OFFER;
        end
        OFFER: if (i_frame_ready) begin
          wd    <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: if (i_tx_done || wd_expired) begin
          frame_cnt <= i_tx_done ? frame_cnt + 16'd1 : frame_cnt;
          o_timeout <= !i_tx_done;
          o_grant   <= '0;
          gap       <= '0;
          state     <= AFTER;
        end else begin
          wd <= wd + 1'b1;
        end
        default: if (gap == GW'(IFG_CYCLES - 1)) state <= IDLE;
          else gap <= gap + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_mhp_tx_scheduler.sv
// tb_mhp_tx_scheduler: directed self-checking bench for mhp_tx_scheduler
module tb_mhp_tx_scheduler;
  localparam int N  = 4;
  localparam int FW = 408;
  localparam int IFG = 4;
  localparam int TO = 1024;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*FW-1:0] req_frame;
  logic [FW-1:0]   frame;
  logic            frame_valid;
  logic            frame_ready = 1'b1;
  logic            tx_done = 1'b0;
  logic [N-1:0]    grant;
  logic            busy;
  logic            timeout;
  logic [15:0]     frame_count;
  logic [FW-1:0]   frm [N];
  logic [FW-1:0]   held;
  int              total = 0;
  int              passed = 0;
  int              n;
  logic            ok;
  mhp_tx_scheduler #(.NUM_REQ(N), .FRAME_W(FW), .IFG_CYCLES(IFG), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_frame(req_frame), .o_frame(frame), .o_frame_valid(frame_valid),
    .i_frame_ready(frame_ready), .i_tx_done(tx_done), .o_grant(grant),
    .o_busy(busy), .o_timeout(timeout), .o_frame_count(frame_count)
  );
  always #5 clk = ~clk;
  always_comb begin
    req_frame = '0;
    for (int i = 0; i < N; i++) req_frame[i*FW +: FW] = frm[i];
  end
  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input string tag);
    int k = 0;
    while (!frame_valid && k < 100) begin
      tick();
      k++;
    end
    if (!frame_valid) chk(tag, 0, 1);
  endtask
  initial begin
    for (int i = 0; i < N; i++) frm[i] = {51{8'(8'hA0 + i)}};
    frm[0][15:0] = 16'h0102;
    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame", frame, 0);
    chk("rst_valid", frame_valid, 0);
    chk("rst_count", frame_count, 0);
    rst = 1'b0;
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    chk("t1_valid", frame_valid, 1);
    chk("t1_dst", frame[15:0], 16'h0102);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_ready_off", req_ready, 0);
    req_valid = '0;
    tick();
    chk("t1_valid_drop", frame_valid, 0);
    repeat (50) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t1_count", frame_count, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_valid("t2_wait");
      chk("t2_grant", grant, 4'b0001 << (i % N));
      chk("t2_frame", frame, frm[i % N]);
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      if (i < 4) begin
        n = 0;
        while (!frame_valid && n < 50) begin
          tick();
          n++;
        end
        // IFG gap cycles plus the single IDLE accept cycle before the next offer
        chk("t2_ifg", n, IFG + 1);
      end
    end
    frame_ready = 1'b0;
    wait_valid("t3_wait");
    chk("t3_grant", grant, 4'b0010);
    held = frame;
    ok = 1'b1;
    repeat (20) begin
      tick();
      ok &= frame_valid && frame == held && !timeout && grant == 4'b0010 && req_ready == 0;
    end
    chk("t3_stable", ok, 1);
    frame_ready = 1'b1;
    tick();
    n = 0;
    while (!timeout && n < 1100) begin
      tick();
      n++;
    end
    chk("t4_latency", n, TO);
    chk("t4_count", frame_count, 5);
    tick();
    chk("t4_pulse", timeout, 0);
    wait_valid("t4_wait");
    chk("t4_next", grant, 4'b0100);
    tick();
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    chk("t5_preset", frame_count, 16'hFFFF);
    repeat (TO - 1) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t5_no_to", timeout, 0);
    chk("t5_wrap", frame_count, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t5_no_to2", timeout, 0);
    chk("t5_done_ignored", frame_count, 0);
    wait_valid("t6_wait");
    chk("t6_grant_pre", grant, 4'b1000);
    tick();
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_grant", grant, 0);
    chk("t6_busy", busy, 0);
    chk("t6_frame", frame, 0);
    chk("t6_valid", frame_valid, 0);
    chk("t6_ready", req_ready, 0);
    req_valid = 4'b0100;
    #2 rst = 1'b0;
    #1;
    chk("t6_rr_ready", req_ready, 4'b0100);
    tick();
    chk("t6_rr_grant", grant, 4'b0100);
    chk("t6_rr_valid", frame_valid, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
